// File: rtl/tim1_pkg.sv
// Shared definitions for the Timer 1 update-event controller:
// FSM state encoding, default repetition-counter width and update-source codes.
package tim1_pkg;

    // Default width of the repetition counter and its reload value.
    localparam int unsigned RCR_W_DEF = 8;

    // Update controller FSM states.
    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    // Update request source select (urs input).
    localparam logic URS_ANY = 1'b0;  // ovf and ug both set uif
    localparam logic URS_OVF = 1'b1;  // only ovf sets uif

endpackage

// File: rtl/tim1_rep_counter.sv
// Repetition down-counter for Timer 1: reloads from rcr, decrements on
// request, otherwise holds. zero flags that the current count is 0.
module tim1_rep_counter
    import tim1_pkg::*;
#(
    parameter int unsigned RCR_W = RCR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic             dec,
    input  logic [RCR_W-1:0] rcr,
    output logic [RCR_W-1:0] cnt,
    output logic             zero
);

    logic [RCR_W-1:0] cnt_q;

    // Reload has priority over decrement; hold when neither is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (reload) begin
            cnt_q <= rcr;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tim1_update_ctrl.sv
// Timer 1 update-event controller. Decides when shadow registers (PSC/CCR and
// ARR) load from their buffers and drives the load strobes straight from
// flops. Also owns the repetition counter, software update (ug), update
// disable, and the sticky update interrupt flag.
// Optional build macro TIM1_UPD_DMA_EN adds an update DMA request/ack pair.
module tim1_update_ctrl
    import tim1_pkg::*;
#(
    parameter int unsigned RCR_W = RCR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             ovf,
    input  logic             ug,
    input  logic             udis,
    input  logic             urs,
    input  logic             arpe,
    input  logic             arr_wr,
    input  logic [RCR_W-1:0] rcr,
    input  logic             uif_clr,
    output logic             ld_sh_reg,
    output logic             ld_arr,
    output logic             cnt_clr,
    output logic             uif,
    output logic [RCR_W-1:0] rep_cnt
`ifdef TIM1_UPD_DMA_EN
    ,
    output logic             upd_dma_req,
    input  logic             upd_dma_ack
`endif
);

    logic [1:0] state_q, state_d;
    logic       pending_q, pending_d;
    logic       pend_uif_q, pend_uif_d;
    logic       ld_sh_reg_q, ld_sh_reg_d;
    logic       ld_arr_q, ld_arr_d;
    logic       arr_pend_q, arr_pend_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic       uif_q, uif_d;

    logic       ug_ok, ovf_ok, ovf_ev, ev, ev_uif;
    logic       rep_zero, rep_reload, rep_dec;
    logic       load, init, uif_set, arr_want;

    // Qualify raw update sources; udis masks both ovf and ug completely.
    always_comb begin
        ug_ok      = ug & ~udis;
        ovf_ok     = ovf & cen & ~udis;
        ovf_ev     = ovf_ok & rep_zero;
        ev         = ug_ok | ovf_ev;
        // An ovf-caused event always flags; a pure ug only when urs allows any source.
        ev_uif     = ovf_ev | (ug_ok & (urs == URS_ANY));
        rep_reload = ug_ok | ovf_ev;
        rep_dec    = ovf_ok & ~rep_zero & ~ug_ok;
    end

    tim1_rep_counter #(
        .RCR_W (RCR_W)
    ) u_rep_counter (
        .clk    (clk),
        .rst    (rst),
        .reload (rep_reload),
        .dec    (rep_dec),
        .rcr    (rcr),
        .cnt    (rep_cnt),
        .zero   (rep_zero)
    );

    // FSM next state: issue a load when idle, otherwise fold the event into pending.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pend_uif_d = pend_uif_q;
        load       = 1'b0;
        init       = 1'b0;
        uif_set    = 1'b0;
        case (state_q)
            S_INIT: begin
                init    = 1'b1;
                state_d = S_RUN;
                if (ev) begin
                    pending_d  = 1'b1;
                    pend_uif_d = pend_uif_q | ev_uif;
                end
            end
            S_RUN: begin
                // The initial load pulse is still high in the first S_RUN cycle,
                // so a new load must wait to keep the strobe's low gap.
                if (!ld_sh_reg_q && (ev || pending_q)) begin
                    load       = 1'b1;
                    uif_set    = ev_uif | pend_uif_q;
                    state_d    = S_LOAD;
                    pending_d  = 1'b0;
                    pend_uif_d = 1'b0;
                end else if (ev) begin
                    pending_d  = 1'b1;
                    pend_uif_d = pend_uif_q | ev_uif;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                if (ev) begin
                    pending_d  = 1'b1;
                    pend_uif_d = pend_uif_q | ev_uif;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Strobe and flag next values; every strobe is gated by its own previous value.
    always_comb begin
        ld_sh_reg_d = init | load;
        arr_want    = init | (load & arpe) | (arr_wr & ~arpe) | arr_pend_q;
        ld_arr_d    = arr_want & ~ld_arr_q;
        arr_pend_d  = arr_want & ld_arr_q;
        cnt_clr_d   = ug_ok & ~cnt_clr_q;
        uif_d       = uif_set | (uif_q & ~uif_clr);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            pending_q   <= 1'b0;
            pend_uif_q  <= 1'b0;
            ld_sh_reg_q <= 1'b0;
            ld_arr_q    <= 1'b0;
            arr_pend_q  <= 1'b0;
            cnt_clr_q   <= 1'b0;
            uif_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_uif_q  <= pend_uif_d;
            ld_sh_reg_q <= ld_sh_reg_d;
            ld_arr_q    <= ld_arr_d;
            arr_pend_q  <= arr_pend_d;
            cnt_clr_q   <= cnt_clr_d;
            uif_q       <= uif_d;
        end
    end

    assign ld_sh_reg = ld_sh_reg_q;
    assign ld_arr    = ld_arr_q;
    assign cnt_clr   = cnt_clr_q;
    assign uif       = uif_q;

`ifdef TIM1_UPD_DMA_EN
    logic dma_req_q, dma_req_d;

    // DMA request rises with uif set and drops the cycle after an ack.
    always_comb begin
        dma_req_d = uif_set | (dma_req_q & ~upd_dma_ack);
    end

    // DMA request register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_req_q <= 1'b0;
        end else begin
            dma_req_q <= dma_req_d;
        end
    end

    assign upd_dma_req = dma_req_q;
`endif

endmodule

// File: tb/tb_tim1_update_ctrl.sv
// Self-checking bench for tim1_update_ctrl: directed scenarios followed by
// random stimulus, all checked against a timestamp-based reference model.
module tb_tim1_update_ctrl;

    localparam int unsigned RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen, ovf, ug, udis, urs, arpe, arr_wr, uif_clr;
    logic [RW-1:0] rcr;
    logic          ld_sh_reg, ld_arr, cnt_clr, uif;
    logic [RW-1:0] rep_cnt;
    logic          dma_ack;
`ifdef TIM1_UPD_DMA_EN
    logic          upd_dma_req;
`endif

    tim1_update_ctrl #(
        .RCR_W (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ovf       (ovf),
        .ug        (ug),
        .udis      (udis),
        .urs       (urs),
        .arpe      (arpe),
        .arr_wr    (arr_wr),
        .rcr       (rcr),
        .uif_clr   (uif_clr),
        .ld_sh_reg (ld_sh_reg),
        .ld_arr    (ld_arr),
        .cnt_clr   (cnt_clr),
        .uif       (uif),
        .rep_cnt   (rep_cnt)
`ifdef TIM1_UPD_DMA_EN
        ,
        .upd_dma_req (upd_dma_req),
        .upd_dma_ack (dma_ack)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    // Reference model: cycle numbers of last/scheduled pulses instead of FSM state.
    int m_rep, m_last_sh, m_sched_sh, m_last_arr, m_sched_arr, m_last_clr;
    bit m_sched_uif, m_uif, m_dma;
    bit e_sh, e_arr, e_clr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_init();
        m_rep       = 0;
        m_last_sh   = -10;
        m_sched_sh  = 1;     // initial load lands in the first cycle after reset
        m_sched_uif = 1'b0;
        m_last_arr  = -10;
        m_sched_arr = 1;
        m_last_clr  = -10;
        m_uif       = 1'b0;
        m_dma       = 1'b0;
        cyc         = 0;
    endtask

    // Predict outputs of cycle cyc+1 from the inputs applied during cycle cyc.
    task automatic model_step();
        int c, tgt;
        bit ug_ok, ovf_ok, ovf_ev, ev, ev_uif, uif_set, want;
        c      = cyc;
        ug_ok  = ug && !udis;
        ovf_ok = ovf && cen && !udis;
        ovf_ev = ovf_ok && (m_rep == 0);
        ev     = ug_ok || ovf_ev;
        ev_uif = ovf_ev || (ug_ok && !urs);

        if (ug_ok || ovf_ev) m_rep = int'(rcr);
        else if (ovf_ok) m_rep = m_rep - 1;

        e_clr = ug_ok && (m_last_clr != c);
        if (e_clr) m_last_clr = c + 1;

        if (ev) begin
            tgt = (m_last_sh == c) ? c + 2 : c + 1;
            if (m_sched_sh < 0) begin
                m_sched_sh  = tgt;
                m_sched_uif = ev_uif;
            end else begin
                m_sched_uif = m_sched_uif || ev_uif;
            end
        end

        e_sh    = (m_sched_sh == c + 1);
        uif_set = 1'b0;
        if (e_sh) begin
            uif_set     = m_sched_uif;
            m_sched_sh  = -1;
            m_sched_uif = 1'b0;
            m_last_sh   = c + 1;
        end

        want  = (e_sh && arpe) || (arr_wr && !arpe) || (m_sched_arr == c + 1);
        e_arr = 1'b0;
        if (want) begin
            if (m_last_arr == c) begin
                m_sched_arr = c + 2;
            end else begin
                e_arr       = 1'b1;
                m_last_arr  = c + 1;
                m_sched_arr = -1;
            end
        end

        m_uif = uif_set || (m_uif && !uif_clr);
        m_dma = uif_set || (m_dma && !dma_ack);
    endtask

    task automatic clear_pulses();
        ovf     = 1'b0;
        ug      = 1'b0;
        arr_wr  = 1'b0;
        uif_clr = 1'b0;
        dma_ack = 1'b0;
    endtask

    // One clock: predict, advance to the next falling edge, compare, drop pulses.
    task automatic cycle();
        model_step();
        @(negedge clk);
        cyc++;
        chk("ld_sh_reg", ld_sh_reg, e_sh);
        chk("ld_arr", ld_arr, e_arr);
        chk("cnt_clr", cnt_clr, e_clr);
        chk("uif", uif, m_uif);
        chk("rep_cnt", rep_cnt, m_rep);
`ifdef TIM1_UPD_DMA_EN
        chk("upd_dma_req", upd_dma_req, m_dma);
`endif
        clear_pulses();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        clear_pulses();
        cen  = 1'b0;
        udis = 1'b0;
        urs  = 1'b0;
        arpe = 1'b0;
        rcr  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ld_sh_reg", ld_sh_reg, 0);
        chk("rst_ld_arr", ld_arr, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_uif", uif, 0);
        chk("rst_rep_cnt", rep_cnt, 0);
        rst = 1'b0;
        model_init();
    endtask

    initial begin
        do_reset();
        repeat (4) cycle();

        // Repetition counter: events on the 1st and 4th overflow.
        rcr = 8'd2;
        cen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ovf = 1'b1;
            cycle();
            repeat (2) cycle();
        end

        // Software update with counter stopped, urs=1 then urs=0.
        cen = 1'b0;
        urs = 1'b1;
        rcr = 8'd5;
        ug  = 1'b1;
        cycle();
        repeat (3) cycle();
        urs = 1'b0;
        ug  = 1'b1;
        cycle();
        repeat (3) cycle();

        // Update disable masks both sources.
        udis = 1'b1;
        cen  = 1'b1;
        ovf  = 1'b1;
        cycle();
        cycle();
        ug = 1'b1;
        cycle();
        repeat (3) cycle();
        udis = 1'b0;

        // ovf event then ug while loading: two separated pulses.
        rcr = 8'd0;
        ug  = 1'b1;
        cycle();
        repeat (3) cycle();
        ovf = 1'b1;
        cycle();
        ug = 1'b1;
        cycle();
        repeat (4) cycle();

        // ARR writes with and without preload, then set/clear collision on uif.
        arpe   = 1'b0;
        arr_wr = 1'b1;
        cycle();
        repeat (3) cycle();
        arpe   = 1'b1;
        arr_wr = 1'b1;
        cycle();
        repeat (3) cycle();
        uif_clr = 1'b1;
        cycle();
        ug      = 1'b1;
        uif_clr = 1'b1;
        cycle();
        repeat (3) cycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ovf     = ($urandom_range(0, 3) == 0);
            ug      = ($urandom_range(0, 15) == 0);
            arr_wr  = ($urandom_range(0, 9) == 0);
            uif_clr = ($urandom_range(0, 7) == 0);
            dma_ack = ($urandom_range(0, 3) == 0);
            cen     = ($urandom_range(0, 7) != 0);
            udis    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) urs = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) arpe = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) rcr = RW'($urandom_range(0, 3));
            cycle();
        end

        // Asynchronous reset in the middle of a load pulse.
        udis = 1'b0;
        repeat (4) cycle();
        ug = 1'b1;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_ld_sh_reg", ld_sh_reg, 0);
        chk("async_ld_arr", ld_arr, 0);
        chk("async_cnt_clr", cnt_clr, 0);
        do_reset();
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tim1_update_ctrl.md
Name: tim1_update_ctrl

Overview:
Update-event controller for Timer 1. It decides when the timer's shadow registers (prescaler, compare, auto-reload) are loaded from their buffer registers. It generates glitch-free, register-driven load strobes that clock the shadow-register blocks, and it implements the repetition counter, software update generation, update disable, and the update interrupt flag. It sits between the timer counter core and the per-register shadow blocks.

Parameters:
RCR_W, 8, width of the repetition counter and its buffer value

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cen  in  1  counter enable
ovf  in  1  counter overflow/underflow, single-cycle pulse from the counter core
ug  in  1  software update generation, single-cycle pulse
udis  in  1  update disable
urs  in  1  update request source; 1 = only ovf-caused updates set uif
arpe  in  1  auto-reload preload enable
arr_wr  in  1  single-cycle pulse when software writes the ARR buffer
rcr  in  RCR_W  repetition counter reload value
uif_clr  in  1  clear update interrupt flag
ld_sh_reg  out  1  load strobe for the PSC/CCR shadow registers
ld_arr  out  1  load strobe for the ARR shadow register
cnt_clr  out  1  counter/prescaler reinitialise pulse
uif  out  1  update interrupt flag, sticky
rep_cnt  out  RCR_W  current repetition count

Behaviour:
- Reset values: all outputs 0, rep_cnt=0, pending=0, FSM in S_INIT.
- Every strobe output (ld_sh_reg, ld_arr, cnt_clr) is a flop output and is never combinational. Each pulse is exactly 1 clk high and is followed by at least 1 clk low.
- FSM states:
  - S_INIT: entered on reset. Next cycle, ld_sh_reg=ld_arr=1 for one cycle (initial load), then go to S_RUN. uif is not set by this load.
  - S_RUN: idle; strobes low.
    - On an update event, go to S_LOAD.
    - If pending=1, go to S_LOAD and clear pending.
  - S_LOAD: ld_sh_reg=1, plus ld_arr=1 when arpe=1. Return to S_RUN unconditionally.
- Update event conditions (udis=0 required):
  - ovf&cen with rep_cnt==0: event; rep_cnt<=rcr.
  - ovf&cen with rep_cnt!=0: no event; rep_cnt<=rep_cnt-1.
  - ug: event regardless of rep_cnt or cen. rep_cnt<=rcr. cnt_clr pulses 1 cycle after ug.
  - ovf and ug in the same cycle: a single event. The ug path takes precedence (rep_cnt<=rcr, cnt_clr pulses).
- udis=1: ovf and ug are ignored entirely. There is no event, no cnt_clr, and rep_cnt holds. A pending flag that is already set is still served.
- An event occurring while in S_LOAD sets pending. Further events while pending=1 merge into that one pending load.
- Latency: event in cycle N; ld_sh_reg high in cycle N+1.
- ld_arr:
  - arpe=1: pulses only together with ld_sh_reg.
  - arpe=0: pulses 1 cycle after arr_wr, and also during S_INIT. It is not asserted with update events.
  - If an arr_wr-driven pulse would fall in the cycle after a previous ld_arr pulse, it is delayed one cycle to keep the low gap.
- uif:
  - Set in the same cycle as the event-driven ld_sh_reg when the source is allowed. urs=0 allows ovf and ug; urs=1 allows ovf only.
  - uif_clr clears uif. A simultaneous set and clear leaves uif=1.
- rst asserted mid-pulse drops all strobes immediately (asynchronous). Shadow blocks reset on the same rst.

Optional Feature:
Macro TIM1_UPD_DMA_EN.
- Defined: adds port upd_dma_req (out, 1) and port upd_dma_ack (in, 1).
  - upd_dma_req is set in the same cycle as any uif-setting event and held high until a cycle with upd_dma_ack=1.
  - It clears the cycle after the ack. A new event in the ack cycle keeps it high.
  - Reset value is 0.
- Undefined: both ports are absent; there is no DMA logic.

Decomposition:
- Shared package tim1_pkg: FSM state encoding (S_INIT, S_RUN, S_LOAD), default RCR_W, and update-source constants (URS_ANY=0, URS_OVF=1).
- One natural sub-module, tim1_rep_counter: the repetition down-counter with reload and hold, with a zero-hit output. All other logic stays in tim1_update_ctrl.

Test Plan:
- Reset release: one ld_sh_reg+ld_arr pulse in the first cycle after rst falls; uif=0, rep_cnt=0.
- rcr=2, cen=1, three ovf pulses: rep_cnt goes 0→2 (event), 1, 0 with no events; the 4th ovf gives an event; ld_sh_reg pulses at the 1st and 4th ovf +1 clk.
- ug with cen=0, urs=1: ld_sh_reg and cnt_clr pulse at +1 clk; rep_cnt=rcr; uif stays 0. Repeat with urs=0: uif=1.
- udis=1 with ovf and ug pulses: no strobes; rep_cnt unchanged; uif unchanged.
- ovf event, then ug in the following cycle (in S_LOAD): two ld_sh_reg pulses separated by ≥1 low cycle.
- arpe=0, arr_wr pulse: ld_arr at +1 clk with ld_sh_reg low; then arpe=1, arr_wr: no ld_arr until the next update event. uif_clr coinciding with a set leaves uif=1.
